mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage that sits directly downstream of `execute`. It takes the ALU result, the store data and the memory-control bits for one instruction, and runs a single load or store against a handshaked data memory. It stalls the upstream stage while the access is outstanding and hands a result to writeback. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles before the access is aborted with an error. Valid range 2–255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid` in 1: `execute` presents a valid instruction this cycle.
- `ALURes` in 16: ALU result, used as the address or as the pass-through result.
- `writeData` in 16: store data (`readdata2` of `execute`).
- `memRead` in 1: the instruction is a load.
- `memWrite` in 1: the instruction is a store.
- `mem_addr` out 16: data-memory address.
- `mem_wdata` out 16: data-memory write data.
- `mem_en` out 1: request strobe, high for exactly one cycle per access.
- `mem_wr` out 1: 1 = write, 0 = read; qualified by `mem_en`.
- `mem_rdata` in 16: read data; valid when `mem_done` is high.
- `mem_done` in 1: access complete; sampled only in WAIT.
- `stall` out 1: upstream stage must hold its outputs.
- `wbData` out 16: result to writeback.
- `wbValid` out 1: `wbData` is valid; a single-cycle pulse per instruction.
- `err` out 1: error pulse, always coincident with `wbValid`.

## Operation
- States are IDLE, REQ and WAIT. The FSM uses a 2-bit state register and an 8-bit WAIT counter `cnt`.
- **IDLE, `valid`, neither memRead nor memWrite:** register `wbData`=`ALURes` and `wbValid`=1 at the next edge. `stall`=0.
- **IDLE, `valid`, both memRead and memWrite:** illegal. Next edge: `wbValid`=1, `err`=1, `wbData`=0. No memory request. `stall`=0.
- **IDLE, `valid`, exactly one of memRead/memWrite:**
  - `stall`=1 combinationally in this cycle.
  - Latch address, data and op.
  - Next state is REQ.
- **REQ:**
  - `mem_en`=1.
  - `mem_addr`/`mem_wdata`/`mem_wr` driven from the latched values.
  - `stall`=1.
  - Clear `cnt`; next state is WAIT.
- **WAIT:**
  - `mem_en`=0. `mem_addr`/`mem_wr`/`mem_wdata` hold their values.
  - If `mem_done`=0: `stall`=1 and `cnt` increments.
  - If `mem_done`=1:
    - `stall`=0 in this same cycle, so upstream advances at this edge.
    - Next edge: `wbValid`=1 and state returns to IDLE.
    - `wbData` = `mem_rdata` for a load, or the latched address for a store.
  - Timeout: if `cnt`=TIMEOUT-1 and `mem_done`=0, abort.
    - `stall`=0 in this cycle.
    - Next edge: `wbValid`=1, `err`=1, `wbData`=0, state returns to IDLE.
    - A later `mem_done` is ignored.
- `mem_done` is ignored in IDLE and REQ.
- `valid` is ignored in REQ and WAIT; upstream is stalled in those states.
- `mem_addr`, `mem_wdata` and `mem_wr` are 0 whenever the state is IDLE.

## Timing
- **Reset values:** state=IDLE, `cnt`=0, and all outputs 0 (`mem_addr`, `mem_wdata`, `mem_en`, `mem_wr`, `stall`, `wbData`, `wbValid`, `err`).
- **Latency:** a non-memory instruction produces `wbValid` 1 cycle after the `valid` cycle. A memory access with `mem_done` N cycles after `mem_en` (N≥1) produces `wbValid` N+2 cycles after the `valid` cycle.
- **Throughput:** one non-memory instruction per cycle. A new instruction may be accepted in the IDLE cycle that follows a completion.
- **Outputs:**
  - `wbValid`, `wbData`, `err` and `cnt` are registered.
  - `mem_en`, `mem_addr`, `mem_wdata` and `mem_wr` are decoded from state and registered data.
  - `stall` is combinational: from `valid`/`memRead`/`memWrite` in IDLE, and from state/`mem_done`/`cnt` in REQ and WAIT.
- **Reset mid-access:** `rst` in REQ or WAIT forces IDLE immediately. `mem_en` and `stall` drop asynchronously, and no `wbValid` is produced for the aborted instruction.

## Configuration
- `MEM_ALIGN_CHECK_EN`
  - **Defined:** a load or store whose `ALURes[0]`=1 is rejected in IDLE. There is no request and `stall`=0. Next edge: `wbValid`=1, `err`=1, `wbData`=0.
  - **Undefined:** bit 0 passes to `mem_addr` unchanged, and odd addresses are accessed normally.

## Test plan
- **Pass-through:** `valid`=1, `ALURes`=16'h1234, no mem op → next cycle `wbValid`=1, `wbData`=16'h1234, `err`=0, `stall`=0 throughout.
- **Load:** `valid`, `memRead`, `ALURes`=16'h0040; `mem_done` with `mem_rdata`=16'hBEEF 3 cycles after `mem_en` →
  - `mem_en` pulses once with `mem_addr`=16'h0040 and `mem_wr`=0.
  - `stall` is high for 4 cycles.
  - `wbData`=16'hBEEF with `wbValid` 5 cycles after `valid`.
- **Store:** `memWrite`, `ALURes`=16'h0010, `writeData`=16'hA5A5, `mem_done` 1 cycle after `mem_en` → `mem_wr`=1, `mem_wdata`=16'hA5A5, `wbValid` 3 cycles after `valid`, `wbData`=16'h0010.
- **Timeout:** load with `mem_done` held low and `TIMEOUT`=4 → after 4 WAIT cycles, `wbValid`=`err`=1 and `wbData`=0. A later `mem_done` produces no second `wbValid`.
- **Illegal op:** `memRead`=`memWrite`=1 → `err` pulse, `mem_en` never asserted.
- **Reset mid-access:** `rst` asserted in WAIT → `stall`/`mem_en`/`wbValid` are 0 immediately. After release, a pass-through of 16'h0001 completes in 1 cycle.
- **Alignment (with `MEM_ALIGN_CHECK_EN`):** load at 16'h0003 → `err`=1, `mem_en`=0. Without the macro → normal access at 16'h0003.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: handshaked load/store stage with stall, timeout and pass-through; optional MEM_ALIGN_CHECK_EN rejects odd addresses.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] ALURes,
  input  logic [15:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall,
  output logic [15:0] wbData,
  output logic        wbValid,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [15:0] addr_q, wdata_q;
  logic wr_q, is_mem, illegal, misalign, accept, done, tmo, last;
  assign is_mem  = memRead ^ memWrite;
  assign illegal = memRead & memWrite;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & ALURes[0];
`else
  assign misalign = 1'b0;
`endif
  assign accept = valid & is_mem & ~misalign;
  assign last   = cnt == 8'(TIMEOUT - 1);
  assign done   = (state == WAIT) & mem_done;
  assign tmo    = (state == WAIT) & ~mem_done & last;
  always_comb begin
    state_n   = state == IDLE ? (accept ? REQ : IDLE) :
                state == REQ  ? WAIT : ((done | tmo) ? IDLE : WAIT);
    stall     = state == IDLE ? accept : state == REQ ? 1'b1 : ~(mem_done | last);
    mem_en    = state == REQ;
    mem_addr  = state == IDLE ? 16'h0 : addr_q;
    mem_wdata = state == IDLE ? 16'h0 : wdata_q;
    mem_wr    = state == IDLE ? 1'b0 : wr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'h0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      wr_q    <= 1'b0;
      wbData  <= 16'h0;
      wbValid <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      wbValid <= 1'b0;
      err     <= 1'b0;
      cnt     <= state == REQ ? 8'h0 : (state == WAIT && !mem_done && !last) ? cnt + 8'h1 : cnt;
      if (state == IDLE && accept) begin
        addr_q  <= ALURes;
        wdata_q <= writeData;
        wr_q    <= memWrite;
      end
      if (state == IDLE && valid && !accept) begin
        wbValid <= 1'b1;
        err     <= illegal | misalign;
        wbData  <= (illegal | misalign) ? 16'h0 : ALURes;
      end else if (done) begin
        wbValid <= 1'b1;
        wbData  <= wr_q ? addr_q : mem_rdata;
      end else if (tmo) begin
        wbValid <= 1'b1;
        err     <= 1'b1;
        wbData  <= 16'h0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenario tasks for mem_stage built with TIMEOUT=4.
module tb_mem_stage;
  logic clk = 0, rst = 1, valid = 0, memRead = 0, memWrite = 0, mem_done = 0;
  logic [15:0] ALURes = 0, writeData = 0, mem_rdata = 0;
  logic [15:0] mem_addr, mem_wdata, wbData;
  logic mem_en, mem_wr, stall, wbValid, err;
  int total = 0, passed = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ALURes(ALURes), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall(stall), .wbData(wbData), .wbValid(wbValid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    valid = v; memRead = rd; memWrite = wr; ALURes = a; writeData = d;
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    total++; if (mem_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", mem_addr); else passed++;
    total++; if ({mem_en, mem_wr, stall, wbValid, err} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {mem_en, mem_wr, stall, wbValid, err}); else passed++;
    total++; if (wbData !== 16'h0 || mem_wdata !== 16'h0) $display("FAIL reset_data got %h/%h want 0000/0000", wbData, mem_wdata); else passed++;
    rst = 0;
  endtask

  task automatic test_passthrough;
    tick; drive(1, 0, 0, 16'h1234, 16'h0);
    total++; if (stall !== 1'b0) $display("FAIL pt_stall got %b want 0", stall); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({wbValid, err, wbData} !== {2'b10, 16'h1234}) $display("FAIL pt_wb got %b%b %h want 10 1234", wbValid, err, wbData); else passed++;
    tick;
    total++; if (wbValid !== 1'b0) $display("FAIL pt_pulse got %b want 0", wbValid); else passed++;
  endtask

  task automatic test_load;
    drive(1, 1, 0, 16'h0040, 16'h0);
    total++; if ({stall, mem_en} !== 2'b10) $display("FAIL ld_c0 got %b want 10", {stall, mem_en}); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({mem_en, mem_wr, stall, mem_addr} !== {3'b101, 16'h0040}) $display("FAIL ld_req got %b %h want 101 0040", {mem_en, mem_wr, stall}, mem_addr); else passed++;
    tick;
    total++; if ({mem_en, stall, mem_addr} !== {2'b01, 16'h0040}) $display("FAIL ld_wait got %b %h want 01 0040", {mem_en, stall}, mem_addr); else passed++;
    tick;
    total++; if ({mem_en, stall, wbValid} !== 3'b010) $display("FAIL ld_wait2 got %b want 010", {mem_en, stall, wbValid}); else passed++;
    tick; mem_done = 1; mem_rdata = 16'hBEEF; #1;
    total++; if (stall !== 1'b0) $display("FAIL ld_done_stall got %b want 0", stall); else passed++;
    tick; mem_done = 0; mem_rdata = 16'h0; drive(1, 0, 0, 16'h0077, 16'h0);
    total++; if ({wbValid, err, wbData} !== {2'b10, 16'hBEEF}) $display("FAIL ld_wb got %b%b %h want 10 beef", wbValid, err, wbData); else passed++;
    total++; if ({stall, mem_addr} !== 17'h0) $display("FAIL ld_idle got %b %h want 0 0000", stall, mem_addr); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({wbValid, wbData} !== {1'b1, 16'h0077}) $display("FAIL ld_next got %b %h want 1 0077", wbValid, wbData); else passed++;
  endtask

  task automatic test_store;
    tick; drive(1, 0, 1, 16'h0010, 16'hA5A5);
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({mem_en, mem_wr, mem_wdata, mem_addr} !== {2'b11, 16'hA5A5, 16'h0010}) $display("FAIL st_req got %b%b %h %h want 11 a5a5 0010", mem_en, mem_wr, mem_wdata, mem_addr); else passed++;
    tick; mem_done = 1; #1;
    total++; if ({stall, mem_wr, mem_en} !== 3'b010) $display("FAIL st_done got %b want 010", {stall, mem_wr, mem_en}); else passed++;
    tick; mem_done = 0; #1;
    total++; if ({wbValid, err, wbData} !== {2'b10, 16'h0010}) $display("FAIL st_wb got %b%b %h want 10 0010", wbValid, err, wbData); else passed++;
  endtask

  task automatic test_timeout;
    tick; drive(1, 1, 0, 16'h0080, 16'h0);
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    tick; tick; tick;
    total++; if ({stall, wbValid} !== 2'b10) $display("FAIL to_wait got %b want 10", {stall, wbValid}); else passed++;
    tick;
    total++; if ({stall, wbValid} !== 2'b00) $display("FAIL to_last got %b want 00", {stall, wbValid}); else passed++;
    tick; mem_done = 1; mem_rdata = 16'hFFFF; #1;
    total++; if ({wbValid, err, wbData} !== {2'b11, 16'h0}) $display("FAIL to_wb got %b%b %h want 11 0000", wbValid, err, wbData); else passed++;
    tick; mem_done = 0; mem_rdata = 16'h0; #1;
    total++; if ({wbValid, mem_en, stall} !== 3'b000) $display("FAIL to_late got %b want 000", {wbValid, mem_en, stall}); else passed++;
  endtask

  task automatic test_illegal;
    tick; drive(1, 1, 1, 16'h5555, 16'h1111);
    total++; if ({stall, mem_en} !== 2'b00) $display("FAIL il_c0 got %b want 00", {stall, mem_en}); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({wbValid, err, mem_en, wbData} !== {3'b110, 16'h0}) $display("FAIL il_wb got %b %h want 110 0000", {wbValid, err, mem_en}, wbData); else passed++;
  endtask

  task automatic test_reset_mid;
    tick; drive(1, 1, 0, 16'h0200, 16'h0);
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    tick;
    total++; if (stall !== 1'b1) $display("FAIL rm_wait got %b want 1", stall); else passed++;
    #2 rst = 1; #1;
    total++; if ({stall, mem_en, wbValid, mem_addr} !== 19'h0) $display("FAIL rm_async got %b %h want 000 0000", {stall, mem_en, wbValid}, mem_addr); else passed++;
    tick; rst = 0;
    tick; drive(1, 0, 0, 16'h0001, 16'h0);
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({wbValid, err, wbData} !== {2'b10, 16'h0001}) $display("FAIL rm_pt got %b%b %h want 10 0001", wbValid, err, wbData); else passed++;
  endtask

  task automatic test_align;
    tick; drive(1, 1, 0, 16'h0003, 16'h0);
`ifdef MEM_ALIGN_CHECK_EN
    total++; if ({stall, mem_en} !== 2'b00) $display("FAIL al_c0 got %b want 00", {stall, mem_en}); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({wbValid, err, mem_en, wbData} !== {3'b110, 16'h0}) $display("FAIL al_wb got %b %h want 110 0000", {wbValid, err, mem_en}, wbData); else passed++;
`else
    total++; if (stall !== 1'b1) $display("FAIL al_c0 got %b want 1", stall); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({mem_en, mem_addr} !== {1'b1, 16'h0003}) $display("FAIL al_req got %b %h want 1 0003", mem_en, mem_addr); else passed++;
    tick; mem_done = 1; mem_rdata = 16'h1357; #1;
    tick; mem_done = 0; mem_rdata = 16'h0; #1;
    total++; if ({wbValid, err, wbData} !== {2'b10, 16'h1357}) $display("FAIL al_wb got %b%b %h want 10 1357", wbValid, err, wbData); else passed++;
`endif
  endtask

  task automatic test_back_to_back;
    tick; drive(1, 0, 0, 16'h000A, 16'h0);
    tick; drive(1, 0, 0, 16'h000B, 16'h0);
    total++; if ({wbValid, wbData, stall} !== {1'b1, 16'h000A, 1'b0}) $display("FAIL bb_0 got %b %h %b want 1 000a 0", wbValid, wbData, stall); else passed++;
    tick; drive(0, 0, 0, 16'h0, 16'h0);
    total++; if ({wbValid, wbData} !== {1'b1, 16'h000B}) $display("FAIL bb_1 got %b %h want 1 000b", wbValid, wbData); else passed++;
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_load;
    test_store;
    test_timeout;
    test_illegal;
    test_reset_mid;
    test_align;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
